sta_path_harness: RTL
=====================

// Module: sta_path_harness
// PURPOSE
//  Parametrised successor to the single-channel STA stage top. Drives CH live operand
//  channels into a pipelined multiply path and a synthetic slow adder/rotate chain.
//  Selects or mixes the two paths per issued sample, XOR-combines channels into dout,
//  and compresses results into a 32-bit signature. All paths stay live in the netlist.
// PARAMETERS
//  W        16  operand width, legal 4..16; result width R = 2*W
//  CH       2   number of operand channels, legal 1..8
//  PIPE     2   register stages after the multiply, legal 0..4
//  SLOW_LEN 8   slow-chain stage count, legal 1..32
// PORTS
//  clk        in   1   clock, rising edge
//  reset_n    in   1   asynchronous, active-low reset
//  en         in   1   issue strobe: sample operands, advance generators
//  mode       in   2   00 real, 01 slow, 10 mix, 11 alternate; sampled at issue
//  dout       out  R   combined result, registered
//  dout_valid out  1   one-cycle pulse per issued sample
//  sig        out  32  MISR signature of all valid dout values
// BEHAVIOUR
//  - Reset: counters to seeds, all pipeline valids 0, dout=0, dout_valid=0, sig=0, alt_ph=0.
//    Async reset mid-pipeline discards in-flight samples; no valid pulse follows for them.
//  - Channel k operands (W bits, 0-based k):
//    - Reset seeds: a=1+k, b=3+k, c=5+k.
//    - On en=1: a+=1, b+=2, c+=3, wrapping mod 2^W. en=0 holds the counters.
//  - Issue cycle: a cycle with en=1. It uses the pre-increment counter values and
//    captures mode and alt_ph into the sample's sideband.
//  - Real path: y_real = ((a*b) * c) truncated to R bits (unsigned).
//    - Registered once at issue, then PIPE further stages.
//  - Slow path (combinational, registered once at issue, then delayed to align with the real path):
//    - s0 = zero-extended (a ^ b).
//    - For i = 1..SLOW_LEN: s_i = rotl1((s_{i-1} + c) mod 2^R).
//    - y_slow = s_SLOW_LEN.
//  - Per-channel select, using the mode captured at issue:
//    - 00: y_real
//    - 01: y_slow
//    - 10: y_real ^ (y_slow >> 1)
//    - 11: y_real if alt_ph=0, else y_slow
//  - alt_ph toggles on every issue, regardless of mode.
//  - dout <= XOR over all channels of their selected values.
//  - Latency: issue at edge t gives dout/dout_valid at edge t+PIPE+2. Throughput is 1/cycle.
//  - en=0 cycles insert bubbles (dout_valid=0). dout holds its last value during bubbles.
//  - Back-to-back issues produce back-to-back valids in order. No stalls; no backpressure.
//  - On each dout_valid cycle:
//    - d32 = dout zero-extended to 32 bits.
//    - sig <= {sig[30:0], sig[31]^sig[21]^sig[1]^sig[0]} ^ d32. Otherwise sig holds.
//  - mode changes between issues take effect only for the next issued sample.
//  - In-flight samples keep their captured mode.
// CONFIGURATION
//  SLOW_CHAIN_EN defined:
//    - Slow chain built as above; all four modes functional.
//  SLOW_CHAIN_EN undefined:
//    - No slow-chain logic; y_slow is constant 0.
//    - Mode 01 yields 0 data with a normal valid pulse.
//    - Mode 10 equals y_real.
//    - Mode 11 alternates y_real and 0.
//  - Latency and valid timing are identical in both builds.
// TESTING (W=16, SLOW_LEN=3, PIPE=2, SLOW_CHAIN_EN defined unless noted)
//  1. CH=1, mode=00, en=1 for 2 cycles after reset -> dout=15 then 80. Valids at t+4, t+5.
//  2. CH=1, single issue in mode 01 -> dout=86; in mode 10 -> dout=15^(86>>1)=36.
//  3. CH=2, mode=00, single issue -> ch0=15, ch1=48 -> dout=63. dout_valid high exactly 1 cycle.
//  4. CH=1, mode=11, 4 issues -> alternates real/slow, starting with real (15).
//     Mode changes mid-flight leave queued samples unchanged.
//  5. W=4, en held 16 cycles -> counters wrap to seeds. Products truncate to 8 bits.
//     en gaps produce bubbles with dout held.
//  6. Reset asserted with 2 samples in flight -> dout=0, sig=0, no stray valid.
//     Rebuild without SLOW_CHAIN_EN: mode 01 gives dout=0 with valid.

Source files
------------

// File: rtl/sta_path_harness.sv
// Multi-channel STA harness: pipelined multiply path plus an optional slow add/rotate chain,
// channel XOR into dout and a 32-bit MISR signature. Slow chain built only with SLOW_CHAIN_EN.
module sta_path_harness #(
    parameter int unsigned W        = 16,
    parameter int unsigned CH       = 2,
    parameter int unsigned PIPE     = 2,
    parameter int unsigned SLOW_LEN = 8,
    localparam int unsigned R       = 2 * W
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic [1:0]   mode,
    output logic [R-1:0] dout,
    output logic         dout_valid,
    output logic [31:0]  sig
);

    if (W < 4 || W > 16 || CH < 1 || CH > 8 || PIPE > 4 || SLOW_LEN < 1 || SLOW_LEN > 32) begin
        $error("sta_path_harness: parameter out of legal range");
    end

    logic [W-1:0] a_q [CH];
    logic [W-1:0] b_q [CH];
    logic [W-1:0] c_q [CH];
    logic         alt_ph_q;

    logic [R-1:0] y_real [CH];
    logic [R-1:0] y_slow [CH];

    // Stage 0 is the issue register; stages 1..PIPE follow it.
    logic [R-1:0] real_q [PIPE+1][CH];
    logic [R-1:0] slow_q [PIPE+1][CH];
    logic [1:0]   mode_q [PIPE+1];
    logic         alt_q  [PIPE+1];
    logic         vld_q  [PIPE+1];

    logic [R-1:0] sel_d [CH];
    logic [R-1:0] sel_q [CH];
    logic         sel_vld_q;
    logic [R-1:0] dout_d;

    always_comb begin
        for (int k = 0; k < CH; k++) begin
            y_real[k] = {{W{1'b0}}, a_q[k]} * {{W{1'b0}}, b_q[k]} * {{W{1'b0}}, c_q[k]};
        end
    end

`ifdef SLOW_CHAIN_EN
    logic [R-1:0] s_acc;

    always_comb begin
        s_acc = '0;
        for (int k = 0; k < CH; k++) begin
            s_acc = {{W{1'b0}}, a_q[k] ^ b_q[k]};
            for (int i = 0; i < int'(SLOW_LEN); i++) begin
                s_acc = s_acc + {{W{1'b0}}, c_q[k]};
                s_acc = {s_acc[R-2:0], s_acc[R-1]};
            end
            y_slow[k] = s_acc;
        end
    end
`else
    always_comb begin
        for (int k = 0; k < CH; k++) begin
            y_slow[k] = '0;
        end
    end
`endif

    always_comb begin
        for (int k = 0; k < CH; k++) begin
            sel_d[k] = real_q[PIPE][k];
            case (mode_q[PIPE])
                2'b00:   sel_d[k] = real_q[PIPE][k];
                2'b01:   sel_d[k] = slow_q[PIPE][k];
                2'b10:   sel_d[k] = real_q[PIPE][k] ^ (slow_q[PIPE][k] >> 1);
                default: sel_d[k] = alt_q[PIPE] ? slow_q[PIPE][k] : real_q[PIPE][k];
            endcase
        end
    end

    always_comb begin
        dout_d = '0;
        for (int k = 0; k < CH; k++) begin
            dout_d ^= sel_q[k];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < CH; k++) begin
                a_q[k]   <= W'(k + 1);
                b_q[k]   <= W'(k + 3);
                c_q[k]   <= W'(k + 5);
                sel_q[k] <= '0;
            end
            for (int s = 0; s <= int'(PIPE); s++) begin
                vld_q[s]  <= 1'b0;
                mode_q[s] <= 2'b00;
                alt_q[s]  <= 1'b0;
                for (int k = 0; k < CH; k++) begin
                    real_q[s][k] <= '0;
                    slow_q[s][k] <= '0;
                end
            end
            alt_ph_q   <= 1'b0;
            sel_vld_q  <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            sig        <= '0;
        end else begin
            if (en) begin
                for (int k = 0; k < CH; k++) begin
                    a_q[k] <= a_q[k] + W'(1);
                    b_q[k] <= b_q[k] + W'(2);
                    c_q[k] <= c_q[k] + W'(3);
                end
                alt_ph_q  <= ~alt_ph_q;
                real_q[0] <= y_real;
                slow_q[0] <= y_slow;
                mode_q[0] <= mode;
                alt_q[0]  <= alt_ph_q;
            end
            vld_q[0] <= en;
            for (int s = 1; s <= int'(PIPE); s++) begin
                real_q[s] <= real_q[s-1];
                slow_q[s] <= slow_q[s-1];
                mode_q[s] <= mode_q[s-1];
                alt_q[s]  <= alt_q[s-1];
                vld_q[s]  <= vld_q[s-1];
            end
            sel_q     <= sel_d;
            sel_vld_q <= vld_q[PIPE];
            // dout only moves on a valid sample so bubbles hold the last result.
            if (sel_vld_q) begin
                dout <= dout_d;
            end
            dout_valid <= sel_vld_q;
            if (dout_valid) begin
                sig <= {sig[30:0], sig[31] ^ sig[21] ^ sig[1] ^ sig[0]} ^ 32'(dout);
            end
        end
    end

endmodule
